// File: rtl/led_blink_pkg.sv
// Shared definitions for the LED blink arbiter family.
// Holds FSM encodings, blink rate codes and the counter sizing helper.
package led_blink_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_OWN  = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   typedef logic [1:0] rate_t;

   // These codes must match the switch decode of tutorial_led_blink:
   // switch_1 is bit 1, switch_2 is bit 0.
   localparam rate_t RATE_100HZ = 2'b00;
   localparam rate_t RATE_50HZ  = 2'b01;
   localparam rate_t RATE_10HZ  = 2'b10;
   localparam rate_t RATE_1HZ   = 2'b11;

   // Width of a down-counter that must hold max(dwell, gap) - 1.
   // A single bit is kept as a floor so the counter never collapses.
   function automatic int cnt_width(input int dwell, input int gap);
      int m;
      m = (dwell > gap) ? dwell : gap;
      return (m <= 1) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/led_blink_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority selector.
// Ports: i_req (requests), i_ptr (search start) -> o_onehot, o_index, o_valid.
module rr_pick #(
   parameter int N  = 3,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_onehot,
   output logic [IW-1:0] o_index,
   output logic          o_valid
);

   // Walk the requesters starting at the pointer, wrapping modulo N;
   // the first one found owns the result.
   always_comb begin
      int k;
      k        = 0;
      o_onehot = '0;
      o_index  = '0;
      o_valid  = 1'b0;
      for (int i = 0; i < N; i++) begin
         k = (int'(i_ptr) + i) % N;
         if (!o_valid && i_req[k]) begin
            o_valid     = 1'b1;
            o_index     = IW'(k);
            o_onehot[k] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/led_blink_arbiter.sv
// Round-robin owner of the single LED blink block: grants the LED to one
// requester for a dwell time, then blanks it for a gap before the next owner.
// Ports:
//   i_clock, i_reset (sync, active high)
//   i_req[NUM_REQ], i_rate[2*NUM_REQ] (requester k uses [2k+1:2k])
//   o_grant (one-hot owner), o_enable, o_switch_1, o_switch_2, o_busy
module led_blink_arbiter
   import led_blink_pkg::*;
#(
   parameter int NUM_REQ      = 3,
   parameter int DWELL_CYCLES = 25000,
   parameter int GAP_CYCLES   = 2500
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic [NUM_REQ-1:0]   i_req,
   input  logic [2*NUM_REQ-1:0] i_rate,
   output logic [NUM_REQ-1:0]   o_grant,
   output logic                 o_enable,
   output logic                 o_switch_1,
   output logic                 o_switch_2,
   output logic                 o_busy
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = cnt_width(DWELL_CYCLES, GAP_CYCLES);

   localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);
   localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_REQ - 1);

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [IW-1:0] ptr;
   logic [IW-1:0] owner;

   logic [NUM_REQ-1:0] win_onehot;
   logic [IW-1:0]      win_idx;
   logic               win_valid;

   logic          owner_req;
   logic          others_req;
   rate_t         owner_rate;
   rate_t         win_rate;
   logic [IW-1:0] next_ptr;

   rr_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_pick (
      .i_req    (i_req),
      .i_ptr    (ptr),
      .o_onehot (win_onehot),
      .o_index  (win_idx),
      .o_valid  (win_valid)
   );

   // o_grant holds the owner one-hot while in OWN, so it doubles as the
   // mask for "owner still requests" and "someone else is waiting".
   always_comb begin
      owner_req  = |(i_req & o_grant);
      others_req = |(i_req & ~o_grant);
      owner_rate = i_rate[{owner, 1'b0} +: 2];
      win_rate   = i_rate[{win_idx, 1'b0} +: 2];
      next_ptr   = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         ptr        <= '0;
         owner      <= '0;
         o_grant    <= '0;
         o_enable   <= 1'b0;
         o_switch_1 <= 1'b0;
         o_switch_2 <= 1'b0;
         o_busy     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (win_valid) begin
                  state      <= ST_OWN;
                  cnt        <= DWELL_LOAD;
                  ptr        <= next_ptr;
                  owner      <= win_idx;
                  o_grant    <= win_onehot;
                  o_enable   <= 1'b1;
                  o_switch_1 <= win_rate[1];
                  o_switch_2 <= win_rate[0];
                  o_busy     <= 1'b1;
               end else begin
                  cnt        <= '0;
                  o_grant    <= '0;
                  o_enable   <= 1'b0;
                  o_switch_1 <= 1'b0;
                  o_switch_2 <= 1'b0;
                  o_busy     <= 1'b0;
               end
            end

            ST_OWN: begin
               // Early release outranks dwell expiry.
               if (!owner_req || (cnt == '0 && others_req)) begin
                  state      <= ST_GAP;
                  cnt        <= GAP_LOAD;
                  o_grant    <= '0;
                  o_enable   <= 1'b0;
                  o_switch_1 <= 1'b0;
                  o_switch_2 <= 1'b0;
               end else if (cnt == '0) begin
                  // Sole requester: renew in place, pick up a fresh rate.
                  cnt        <= DWELL_LOAD;
                  o_switch_1 <= owner_rate[1];
                  o_switch_2 <= owner_rate[0];
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            ST_GAP: begin
               if (cnt == '0) begin
                  state  <= ST_IDLE;
                  o_busy <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            default: begin
               state      <= ST_IDLE;
               cnt        <= '0;
               o_grant    <= '0;
               o_enable   <= 1'b0;
               o_switch_1 <= 1'b0;
               o_switch_2 <= 1'b0;
               o_busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Self-checking bench for led_blink_arbiter (NUM_REQ=3, DWELL=8, GAP=2).
// Vector table, directed corner sequences and a random run vs. a model.
module tb_led_blink_arbiter;

   localparam int NR = 3;
   localparam int DW = 8;
   localparam int GP = 2;

   logic          clk;
   logic          i_reset;
   logic [NR-1:0] i_req;
   logic [5:0]    i_rate;
   logic [NR-1:0] o_grant;
   logic          o_enable;
   logic          o_switch_1;
   logic          o_switch_2;
   logic          o_busy;

   int n_checks = 0;
   int n_err    = 0;

   led_blink_arbiter #(
      .NUM_REQ      (NR),
      .DWELL_CYCLES (DW),
      .GAP_CYCLES   (GP)
   ) dut (
      .i_clock    (clk),
      .i_reset    (i_reset),
      .i_req      (i_req),
      .i_rate     (i_rate),
      .o_grant    (o_grant),
      .o_enable   (o_enable),
      .o_switch_1 (o_switch_1),
      .o_switch_2 (o_switch_2),
      .o_busy     (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   // Reference model: who owns the LED, how long they have had it,
   // how long the blanking has lasted, and where the search starts.
   localparam int M_IDLE = 0;
   localparam int M_OWN  = 1;
   localparam int M_GAP  = 2;

   int         m_mode  = M_IDLE;
   int         m_owner = 0;
   int         m_held  = 0;
   int         m_dark  = 0;
   int         m_start = 0;
   logic [1:0] m_rate  = 2'b00;

   task automatic model_step(input logic [2:0] req, input logic [5:0] rate,
                             input logic rst);
      bit found;
      int k;
      found = 0;
      if (rst) begin
         m_mode  = M_IDLE;
         m_start = 0;
      end else if (m_mode == M_IDLE) begin
         for (int i = 0; i < NR; i++) begin
            k = (m_start + i) % NR;
            if (!found && req[k]) begin
               found   = 1;
               m_owner = k;
            end
         end
         if (found) begin
            m_mode  = M_OWN;
            m_held  = 1;
            m_rate  = rate[2*m_owner +: 2];
            m_start = (m_owner + 1) % NR;
         end
      end else if (m_mode == M_OWN) begin
         if (!req[m_owner]) begin
            m_mode = M_GAP;
            m_dark = 1;
         end else if (m_held == DW) begin
            if ((req & ~(3'b001 << m_owner)) != 3'b000) begin
               m_mode = M_GAP;
               m_dark = 1;
            end else begin
               m_held = 1;
               m_rate = rate[2*m_owner +: 2];
            end
         end else begin
            m_held++;
         end
      end else begin
         if (m_dark == GP) m_mode = M_IDLE;
         else m_dark++;
      end
   endtask

   task automatic tick(input logic [2:0] req, input logic [5:0] rate,
                       input logic rst);
      logic [2:0] eg;
      i_req   = req;
      i_rate  = rate;
      i_reset = rst;
      model_step(req, rate, rst);
      @(posedge clk);
      #1;
      eg = (m_mode == M_OWN) ? (3'b001 << m_owner) : 3'b000;
      check("model_grant", 32'(o_grant), 32'(eg));
      check("model_enable", 32'(o_enable), 32'(m_mode == M_OWN));
      check("model_switch", 32'({o_switch_1, o_switch_2}),
            32'((m_mode == M_OWN) ? m_rate : 2'b00));
      check("model_busy", 32'(o_busy), 32'(m_mode != M_IDLE));
   endtask

   typedef struct {
      logic       rst;
      logic [2:0] req;
      logic [5:0] rate;
      logic [2:0] grant;
      logic       en;
      logic [1:0] sw;
      logic       busy;
   } vec_t;

   vec_t tbl[14];

   initial begin
      logic [5:0] rt;
      int order[$];
      int hi_len[$];
      int lo_len[$];
      int run;
      int en_cnt;
      bit prev_en;
      bit found;

      i_reset = 1'b1;
      i_req   = '0;
      i_rate  = '0;

      // Reset with all requesting, then first grant and one full cycle.
      rt = 6'b11_10_01;
      tbl[0] = '{1'b1, 3'b111, rt, 3'b000, 1'b0, 2'b00, 1'b0};
      tbl[1] = '{1'b1, 3'b111, rt, 3'b000, 1'b0, 2'b00, 1'b0};
      for (int i = 2; i < 10; i++)
         tbl[i] = '{1'b0, 3'b111, rt, 3'b001, 1'b1, 2'b01, 1'b1};
      tbl[10] = '{1'b0, 3'b111, rt, 3'b000, 1'b0, 2'b00, 1'b1};
      tbl[11] = '{1'b0, 3'b111, rt, 3'b000, 1'b0, 2'b00, 1'b1};
      tbl[12] = '{1'b0, 3'b111, rt, 3'b000, 1'b0, 2'b00, 1'b0};
      tbl[13] = '{1'b0, 3'b111, rt, 3'b010, 1'b1, 2'b10, 1'b1};

      for (int i = 0; i < 14; i++) begin
         tick(tbl[i].req, tbl[i].rate, tbl[i].rst);
         check("tbl_grant", 32'(o_grant), 32'(tbl[i].grant));
         check("tbl_enable", 32'(o_enable), 32'(tbl[i].en));
         check("tbl_switch", 32'({o_switch_1, o_switch_2}), 32'(tbl[i].sw));
         check("tbl_busy", 32'(o_busy), 32'(tbl[i].busy));
      end

      // Single requester keeps the LED through renewals.
      tick(3'b000, 6'b0, 1'b1);
      en_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         tick(3'b010, 6'b00_10_00, 1'b0);
         check("single_grant", 32'(o_grant), 32'h2);
         check("single_switch", 32'({o_switch_1, o_switch_2}), 32'h2);
         if (o_enable) en_cnt++;
      end
      check("single_enable_cycles", 32'(en_cnt), 32'd40);

      // Round-robin order and on/off run lengths.
      tick(3'b111, rt, 1'b1);
      prev_en = 0;
      run     = 0;
      for (int i = 0; i < 40; i++) begin
         tick(3'b111, rt, 1'b0);
         if (o_enable != prev_en) begin
            if (o_enable) begin
               if (order.size() > 0) lo_len.push_back(run);
               case (o_grant)
                  3'b001:  order.push_back(0);
                  3'b010:  order.push_back(1);
                  3'b100:  order.push_back(2);
                  default: order.push_back(-1);
               endcase
            end else begin
               hi_len.push_back(run);
            end
            run = 0;
         end
         run++;
         prev_en = o_enable;
      end
      check("rr_grants_seen", 32'(order.size()), 32'd4);
      if (order.size() >= 4) begin
         check("rr_order0", 32'(order[0]), 32'd0);
         check("rr_order1", 32'(order[1]), 32'd1);
         check("rr_order2", 32'(order[2]), 32'd2);
         check("rr_order3", 32'(order[3]), 32'd0);
      end
      if (hi_len.size() >= 3 && lo_len.size() >= 3) begin
         for (int i = 0; i < 3; i++) begin
            check("rr_on_len", 32'(hi_len[i]), 32'd8);
            check("rr_off_len", 32'(lo_len[i]), 32'd3);
         end
      end else begin
         check("rr_runs_seen", 32'(lo_len.size()), 32'd3);
      end

      // Early release by requester 2 three clocks into its dwell.
      tick(3'b111, rt, 1'b1);
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick(3'b111, rt, 1'b0);
         if (o_grant == 3'b100) found = 1;
      end
      check("early_owner2_found", 32'(found), 32'd1);
      tick(3'b111, rt, 1'b0);
      tick(3'b111, rt, 1'b0);
      check("early_still_on", 32'(o_enable), 32'd1);
      tick(3'b011, rt, 1'b0);
      check("early_enable_off", 32'(o_enable), 32'd0);
      check("early_gap_busy", 32'(o_busy), 32'd1);
      tick(3'b011, rt, 1'b0);
      check("early_gap2_busy", 32'(o_busy), 32'd1);
      tick(3'b011, rt, 1'b0);
      check("early_idle", 32'(o_busy), 32'd0);
      tick(3'b011, rt, 1'b0);
      check("early_next_grant", 32'(o_grant), 32'h1);

      // Owner rate change mid-dwell only shows up at renewal.
      tick(3'b000, 6'b0, 1'b1);
      for (int i = 0; i < 4; i++) tick(3'b001, 6'b00_00_00, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick(3'b001, 6'b00_00_11, 1'b0);
         check("rate_hold", 32'({o_switch_1, o_switch_2}), 32'h0);
      end
      tick(3'b001, 6'b00_00_11, 1'b0);
      check("rate_renewed", 32'({o_switch_1, o_switch_2}), 32'h3);
      check("rate_renew_enable", 32'(o_enable), 32'd1);

      // Reset in the middle of requester 1's dwell.
      tick(3'b000, 6'b0, 1'b1);
      for (int i = 0; i < 5; i++) tick(3'b010, rt, 1'b0);
      check("rst_mid_owner", 32'(o_grant), 32'h2);
      tick(3'b111, rt, 1'b1);
      check("rst_mid_grant", 32'(o_grant), 32'h0);
      check("rst_mid_enable", 32'(o_enable), 32'd0);
      check("rst_mid_busy", 32'(o_busy), 32'd0);
      tick(3'b111, rt, 1'b0);
      check("rst_mid_ptr0", 32'(o_grant), 32'h1);

      // Random traffic with sticky requests and rare resets.
      begin
         logic [2:0] rq;
         logic [5:0] ra;
         rq = 3'b000;
         ra = 6'b0;
         for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 5) == 0) rq = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) ra = 6'($urandom_range(0, 63));
            tick(rq, ra, $urandom_range(0, 99) == 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks,
               n_err);
      $finish;
   end

endmodule
